fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Parametrised instruction-fetch sequencer that assembles INSTR_WIDTH-bit instructions from an external program store over a narrow BUS_WIDTH-bit 4-phase req/ack link.
- Sits between the off-chip program source and the execution core. Generates the chunk address, assembles chunks MSB-first, computes the next PC (sequential or jump), and pulses execution.
- Adds bounded retry on timeout, a sticky fetch error, a configurable tick rate, and a host restart handshake, all in a single clock domain.

Parameters:
- BUS_WIDTH, 8: data bus width per chunk.
- INSTR_WIDTH, 16: instruction width. Must be an integer multiple of BUS_WIDTH. CHUNKS = INSTR_WIDTH/BUS_WIDTH, with CHUNKS ≥ 1.
- PC_WIDTH, 12: instruction-index width.
- ADDR_WIDTH, 8: external chunk-address width.
- TICK_LOG2, 17: the FSM advances once every 2^TICK_LOG2 clk cycles. A value of 0 means every cycle.
- TIMEOUT, 100: ticks allowed per handshake phase.
- MAX_RETRIES, 3: retries per chunk before error.
- JUMP_OPCODE, 4'h1: value of instruction[INSTR_WIDTH-1 -: 4] that selects a jump.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active low.
- data_in, input, BUS_WIDTH: chunk from the program store.
- ack, input, 1: asynchronous handshake acknowledge. Passes through a 2-flop synchroniser.
- host_restart, input, 1: asynchronous host restart request. Passes through a 2-flop synchroniser; its rising edge is detected.
- req, output, 1: handshake request.
- chunk_addr, output, ADDR_WIDTH: equals (pc*CHUNKS + chunk_idx), truncated to ADDR_WIDTH.
- pc, output, PC_WIDTH: index of the instruction currently being fetched.
- instruction, output, INSTR_WIDTH: the assembled instruction.
- exec_pulse, output, 1: one-clk pulse when a complete instruction is available.
- exec_reset, output, 1: high for one clk on an accepted host restart.
- fetch_error, output, 1: sticky flag set when retries are exhausted.
- busy, output, 1: high whenever the FSM is not in HALT or HOLD.

Behaviour:
- Reset values (rst low, applied asynchronously): req=0, pc=0, chunk_idx=0, instruction=0, exec_pulse=0, exec_reset=0, fetch_error=0, retry=0, timeout counter=0, prescaler=0, state=GAP, restart edge latch=0.
- Tick generation:
  - The prescaler counts every clk. tick=1 for one clk when the prescaler is all-ones, and the prescaler then wraps.
  - FSM transitions occur only on tick cycles.
  - The host-restart rising edge is detected at clk rate and latched until it is consumed on a tick.
- FSM states and transitions:
  - GAP: req=0. On the next tick, go to REQ with req=1 and the timeout counter cleared.
  - REQ: wait for ack_sync==1.
    - On ack: capture data_in into instruction slice [INSTR_WIDTH-1-chunk_idx*BUS_WIDTH -: BUS_WIDTH], set req=0, go to REL, clear the timeout counter.
    - Otherwise increment the timeout counter.
  - REL: wait for ack_sync==0.
    - If chunk_idx < CHUNKS-1: chunk_idx+1, clear retry, go to GAP.
    - If chunk_idx is the last chunk: chunk_idx=0, clear retry, assert exec_pulse for that one clk, and update pc, then go to GAP. The pc update is pc=jump target (instruction[PC_WIDTH-1:0]) if the opcode equals JUMP_OPCODE, otherwise pc+1, wrapping modulo 2^PC_WIDTH.
  - Timeout: when the counter reaches TIMEOUT in REQ or REL, set req=0 and leave pc and chunk_idx unchanged.
    - If retry < MAX_RETRIES: retry+1, go to GAP, and the same chunk is re-requested.
    - Otherwise set fetch_error=1 and go to HALT.
  - HALT: req=0 and the FSM is inert. Only a host restart or rst leaves HALT.
  - HOLD: entered on an accepted restart. req=0. Wait for host_restart_sync==0, then go to GAP.
- Host restart:
  - A latched edge is taken on the next tick from any state and has priority over ack and timeout on the same tick.
  - Effects: pc=0, chunk_idx=0, retry=0, fetch_error=0, req=0, exec_reset=1 for that clk, state=HOLD.
  - Any partial instruction is discarded, and exec_pulse is suppressed.
- Outputs:
  - instruction is stable from the exec_pulse clk until the first chunk capture of the next fetch.
  - chunk_addr and pc change only on ticks and are stable whenever req=1.
- Latency: one chunk takes at least 3 ticks (GAP, REQ, REL). With TICK_LOG2=0 and an immediate ack, an instruction takes 3*CHUNKS cycles plus synchroniser delay.

Test Plan:
- TICK_LOG2=0, INSTR_WIDTH=16, BUS_WIDTH=8. The store returns 0x23 then 0x45 at chunk_addr 0 and 1 -> instruction=0x2345, one exec_pulse, pc 0→1, next chunk_addr=2.
- Store returns JUMP_OPCODE word 0x1_0A5 at pc=0 -> exec_pulse, pc=0x0A5, chunk_addr=0x4A (0x14A truncated to 8 bits).
- ack held low, TIMEOUT=4, MAX_RETRIES=2 -> req pulses 3 times, each for 4 ticks, then fetch_error=1, busy=0, req stays 0. A subsequent host_restart pulse -> exec_reset pulse, fetch_error=0, fetch resumes at chunk_addr=0.
- host_restart asserted on the same tick that ack rises on the second chunk -> no exec_pulse, pc=0, instruction capture ignored, FSM waits in HOLD until host_restart falls.
- pc=0xFFF with a non-jump instruction -> pc wraps to 0x000. With INSTR_WIDTH=32 and BUS_WIDTH=8, 4 chunks are captured MSB-first (0xDE, 0xAD, 0xBE, 0xEF -> 0xDEADBEEF).
- rst asserted mid-REL with TICK_LOG2=3 -> immediate req=0, all outputs at reset values, and the first req occurs after the first tick.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Assembles INSTR_WIDTH-bit instructions MSB-first from
//            BUS_WIDTH-bit chunks fetched over a 4-phase req/ack link,
//            computes the next PC (sequential or jump) and pulses execution.
//            Bounded retry on timeout, sticky fetch error, prescaled FSM
//            tick and a host restart handshake, single clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int         BUS_WIDTH   = 8,
    parameter int         INSTR_WIDTH = 16,
    parameter int         PC_WIDTH    = 12,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         TICK_LOG2   = 17,
    parameter int         TIMEOUT     = 100,
    parameter int         MAX_RETRIES = 3,
    parameter logic [3:0] JUMP_OPCODE = 4'h1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_WIDTH-1:0]   data_in,
    input  logic                   ack,
    input  logic                   host_restart,
    output logic                   req,
    output logic [ADDR_WIDTH-1:0]  chunk_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   exec_pulse,
    output logic                   exec_reset,
    output logic                   fetch_error,
    output logic                   busy
);

    localparam int c_CHUNKS = INSTR_WIDTH / BUS_WIDTH;
    localparam int c_IDX_W  = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    // The timeout counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT fires.
    localparam int c_TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_RT_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_GAP  = 3'd0,
        S_REQ  = 3'd1,
        S_REL  = 3'd2,
        S_HALT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_req;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [c_IDX_W-1:0]     r_chunk_idx;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_exec_pulse;
    logic                   r_exec_reset;
    logic                   r_fetch_error;
    logic [c_RT_W-1:0]      r_retry;
    logic [c_TO_W-1:0]      r_to_cnt;

    logic                   r_ack_s1;
    logic                   r_ack_s2;
    logic                   r_hr_s1;
    logic                   r_hr_s2;
    logic                   r_hr_prev;
    logic                   r_restart_pend;

    logic                   w_tick;
    logic                   w_hr_rise;
    logic                   w_timeout;
    logic                   w_retry_ok;
    logic                   w_last_chunk;
    logic [3:0]             w_opcode;
    logic [PC_WIDTH-1:0]    w_pc_next;

    // Prescaler: tick on the all-ones count; with TICK_LOG2 = 0 every clk ticks
    generate
        if (TICK_LOG2 == 0) begin : g_tick_every_clk
            assign w_tick = 1'b1;
        end else begin : g_tick_prescaler
            logic [TICK_LOG2-1:0] r_presc;

            // Free-running prescaler, wraps after the all-ones tick cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            assign w_tick = &r_presc;
        end
    endgenerate

    // Two-flop synchronisers for ack and host_restart, plus restart edge history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_s1  <= 1'b0;
            r_ack_s2  <= 1'b0;
            r_hr_s1   <= 1'b0;
            r_hr_s2   <= 1'b0;
            r_hr_prev <= 1'b0;
        end else begin
            r_ack_s1  <= ack;
            r_ack_s2  <= r_ack_s1;
            r_hr_s1   <= host_restart;
            r_hr_s2   <= r_hr_s1;
            r_hr_prev <= r_hr_s2;
        end
    end

    assign w_hr_rise = r_hr_s2 & ~r_hr_prev;

    // Restart edge is caught at clk rate and held until a tick consumes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_restart_pend <= 1'b0;
        end else begin
            r_restart_pend <= w_hr_rise | (r_restart_pend & ~w_tick);
        end
    end

    assign w_timeout    = (r_to_cnt == c_TO_W'(TIMEOUT - 1));
    assign w_retry_ok   = (r_retry < c_RT_W'(MAX_RETRIES));
    assign w_last_chunk = (r_chunk_idx == c_IDX_W'(c_CHUNKS - 1));
    assign w_opcode     = r_instr[INSTR_WIDTH-1 -: 4];
    assign w_pc_next    = (w_opcode == JUMP_OPCODE) ? r_instr[PC_WIDTH-1:0]
                                                    : r_pc + 1'b1;

    // Fetch FSM: advances on ticks only; restart outranks ack and timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_GAP;
            r_req         <= 1'b0;
            r_pc          <= '0;
            r_chunk_idx   <= '0;
            r_instr       <= '0;
            r_exec_pulse  <= 1'b0;
            r_exec_reset  <= 1'b0;
            r_fetch_error <= 1'b0;
            r_retry       <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_exec_pulse <= 1'b0;
            r_exec_reset <= 1'b0;
            if (w_tick) begin
                if (r_restart_pend) begin
                    r_pc          <= '0;
                    r_chunk_idx   <= '0;
                    r_retry       <= '0;
                    r_fetch_error <= 1'b0;
                    r_req         <= 1'b0;
                    r_to_cnt      <= '0;
                    r_exec_reset  <= 1'b1;
                    r_state       <= S_HOLD;
                end else begin
                    case (r_state)
                        S_GAP: begin
                            r_req    <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_REQ;
                        end
                        S_REQ: begin
                            if (r_ack_s2) begin
                                for (int k = 0; k < c_CHUNKS; k++) begin
                                    if (r_chunk_idx == c_IDX_W'(k)) begin
                                        r_instr[INSTR_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH] <= data_in;
                                    end
                                end
                                r_req    <= 1'b0;
                                r_to_cnt <= '0;
                                r_state  <= S_REL;
                            end else if (w_timeout) begin
                                r_req    <= 1'b0;
                                r_to_cnt <= '0;
                                if (w_retry_ok) begin
                                    r_retry <= r_retry + 1'b1;
                                    r_state <= S_GAP;
                                end else begin
                                    r_fetch_error <= 1'b1;
                                    r_state       <= S_HALT;
                                end
                            end else begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                        end
                        S_REL: begin
                            if (!r_ack_s2) begin
                                r_retry  <= '0;
                                r_to_cnt <= '0;
                                r_state  <= S_GAP;
                                if (w_last_chunk) begin
                                    r_chunk_idx  <= '0;
                                    r_exec_pulse <= 1'b1;
                                    r_pc         <= w_pc_next;
                                end else begin
                                    r_chunk_idx <= r_chunk_idx + 1'b1;
                                end
                            end else if (w_timeout) begin
                                r_req    <= 1'b0;
                                r_to_cnt <= '0;
                                if (w_retry_ok) begin
                                    r_retry <= r_retry + 1'b1;
                                    r_state <= S_GAP;
                                end else begin
                                    r_fetch_error <= 1'b1;
                                    r_state       <= S_HALT;
                                end
                            end else begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                        end
                        S_HALT: begin
                            r_req <= 1'b0;
                        end
                        S_HOLD: begin
                            r_req <= 1'b0;
                            if (!r_hr_s2) begin
                                r_state <= S_GAP;
                            end
                        end
                        default: begin
                            r_req   <= 1'b0;
                            r_state <= S_GAP;
                        end
                    endcase
                end
            end
        end
    end

    // Address is a pure function of registered pc/chunk_idx, so it only moves on ticks
    assign chunk_addr  = ADDR_WIDTH'(32'(r_pc) * 32'(c_CHUNKS) + 32'(r_chunk_idx));
    assign req         = r_req;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign exec_pulse  = r_exec_pulse;
    assign exec_reset  = r_exec_reset;
    assign fetch_error = r_fetch_error;
    assign busy        = (r_state != S_HALT) && (r_state != S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed self-checking bench for fetch_sequencer using three
//            instances: 16-bit fast tick, 32-bit fast tick, 16-bit slow tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- instance A: 16/8, TICK_LOG2=0, TIMEOUT=4, MAX_RETRIES=2
    logic        a_rst = 1'b1;
    logic        a_auto = 1'b0;
    logic        a_ack_man = 1'b0;
    logic        a_hr = 1'b0;
    logic [7:0]  a_data;
    logic        a_ack;
    logic        a_req;
    logic [7:0]  a_addr;
    logic [11:0] a_pc;
    logic [15:0] a_instr;
    logic        a_exec, a_xrst, a_err, a_busy;
    logic [7:0]  mem_a [256];

    assign a_data = mem_a[a_addr];
    assign a_ack  = a_auto ? a_req : a_ack_man;

    fetch_sequencer #(
        .BUS_WIDTH(8), .INSTR_WIDTH(16), .PC_WIDTH(12), .ADDR_WIDTH(8),
        .TICK_LOG2(0), .TIMEOUT(4), .MAX_RETRIES(2), .JUMP_OPCODE(4'h1)
    ) dut_a (
        .clk(clk), .rst(a_rst), .data_in(a_data), .ack(a_ack),
        .host_restart(a_hr), .req(a_req), .chunk_addr(a_addr), .pc(a_pc),
        .instruction(a_instr), .exec_pulse(a_exec), .exec_reset(a_xrst),
        .fetch_error(a_err), .busy(a_busy)
    );

    // ---------------- instance B: 32/8, TICK_LOG2=0
    logic        b_rst = 1'b1;
    logic        b_hr = 1'b0;
    logic [7:0]  b_data;
    logic        b_req;
    logic [7:0]  b_addr;
    logic [11:0] b_pc;
    logic [31:0] b_instr;
    logic        b_exec, b_xrst, b_err, b_busy;
    logic [7:0]  mem_b [256];

    assign b_data = mem_b[b_addr];

    fetch_sequencer #(
        .BUS_WIDTH(8), .INSTR_WIDTH(32), .PC_WIDTH(12), .ADDR_WIDTH(8),
        .TICK_LOG2(0), .TIMEOUT(100), .MAX_RETRIES(3), .JUMP_OPCODE(4'h1)
    ) dut_b (
        .clk(clk), .rst(b_rst), .data_in(b_data), .ack(b_req),
        .host_restart(b_hr), .req(b_req), .chunk_addr(b_addr), .pc(b_pc),
        .instruction(b_instr), .exec_pulse(b_exec), .exec_reset(b_xrst),
        .fetch_error(b_err), .busy(b_busy)
    );

    // ---------------- instance C: 16/8, TICK_LOG2=3
    logic        c_rst = 1'b1;
    logic        c_hr = 1'b0;
    logic [7:0]  c_data;
    logic        c_req;
    logic [7:0]  c_addr;
    logic [11:0] c_pc;
    logic [15:0] c_instr;
    logic        c_exec, c_xrst, c_err, c_busy;
    logic [7:0]  mem_c [256];

    assign c_data = mem_c[c_addr];

    fetch_sequencer #(
        .BUS_WIDTH(8), .INSTR_WIDTH(16), .PC_WIDTH(12), .ADDR_WIDTH(8),
        .TICK_LOG2(3), .TIMEOUT(100), .MAX_RETRIES(3), .JUMP_OPCODE(4'h1)
    ) dut_c (
        .clk(clk), .rst(c_rst), .data_in(c_data), .ack(c_req),
        .host_restart(c_hr), .req(c_req), .chunk_addr(c_addr), .pc(c_pc),
        .instruction(c_instr), .exec_pulse(c_exec), .exec_reset(c_xrst),
        .fetch_error(c_err), .busy(c_busy)
    );

    // ------------------------------------------------------------------------
    task automatic init_mems();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
            mem_c[i] = 8'h00;
        end
        mem_a[8'h00] = 8'h23; mem_a[8'h01] = 8'h45;
        mem_a[8'h02] = 8'h10; mem_a[8'h03] = 8'hA5;
        mem_a[8'h4A] = 8'h1F; mem_a[8'h4B] = 8'hFF;
        mem_a[8'hFE] = 8'h23; mem_a[8'hFF] = 8'h45;
        mem_b[8'h00] = 8'hDE; mem_b[8'h01] = 8'hAD;
        mem_b[8'h02] = 8'hBE; mem_b[8'h03] = 8'hEF;
        mem_c[8'h00] = 8'h23; mem_c[8'h01] = 8'h45;
    endtask

    task automatic wait_exec_a(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (a_exec) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req_a(input logic level, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (a_req == level) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        #2;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_req !== 1'b0)    $display("FAIL reset_req: got %0b want 0", a_req);      else n_pass++;
        n_checks++; if (a_pc !== 12'h000)  $display("FAIL reset_pc: got %h want 000", a_pc);       else n_pass++;
        n_checks++; if (a_addr !== 8'h00)  $display("FAIL reset_addr: got %h want 00", a_addr);    else n_pass++;
        n_checks++; if (a_instr !== 16'h0) $display("FAIL reset_instr: got %h want 0000", a_instr); else n_pass++;
        n_checks++; if (a_exec !== 1'b0)   $display("FAIL reset_exec: got %0b want 0", a_exec);    else n_pass++;
        n_checks++; if (a_xrst !== 1'b0)   $display("FAIL reset_xrst: got %0b want 0", a_xrst);    else n_pass++;
        n_checks++; if (a_err !== 1'b0)    $display("FAIL reset_err: got %0b want 0", a_err);      else n_pass++;
        n_checks++; if (a_busy !== 1'b1)   $display("FAIL reset_busy: got %0b want 1", a_busy);    else n_pass++;
    endtask

    task automatic test_timeout();
        int   pulses;
        int   w;
        int   wmin;
        int   wmax;
        logic prev;
        pulses = 0; w = 0; wmin = 999; wmax = 0; prev = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (a_req) w++;
            if (a_req && !prev) pulses++;
            if (!a_req && prev) begin
                if (w < wmin) wmin = w;
                if (w > wmax) wmax = w;
                w = 0;
            end
            prev = a_req;
        end
        n_checks++; if (pulses != 3)     $display("FAIL timeout_pulses: got %0d want 3", pulses); else n_pass++;
        n_checks++; if (wmin != 4)       $display("FAIL timeout_wmin: got %0d want 4", wmin);     else n_pass++;
        n_checks++; if (wmax != 4)       $display("FAIL timeout_wmax: got %0d want 4", wmax);     else n_pass++;
        n_checks++; if (a_err !== 1'b1)  $display("FAIL timeout_err: got %0b want 1", a_err);     else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL timeout_busy: got %0b want 0", a_busy);   else n_pass++;
        n_checks++; if (a_req !== 1'b0)  $display("FAIL timeout_req: got %0b want 0", a_req);     else n_pass++;
    endtask

    task automatic test_restart_from_halt();
        int xr;
        bit got;
        xr = 0;
        a_auto = 1'b1;
        a_hr   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_xrst) xr++;
        end
        n_checks++; if (a_err !== 1'b0)  $display("FAIL restart_err_clear: got %0b want 0", a_err); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL restart_hold_busy: got %0b want 0", a_busy); else n_pass++;
        a_hr = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_xrst) xr++;
            if (a_req) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++; if (!got)            $display("FAIL restart_resume: got no req want req"); else n_pass++;
        n_checks++; if (a_addr !== 8'h00) $display("FAIL restart_addr: got %h want 00", a_addr); else n_pass++;
        n_checks++; if (xr != 1)         $display("FAIL restart_xrst_count: got %0d want 1", xr); else n_pass++;
    endtask

    task automatic test_sequential_and_jump();
        logic [15:0] exp_instr [4];
        logic [11:0] exp_pc    [4];
        logic [7:0]  exp_addr  [4];
        bit          got;
        exp_instr[0] = 16'h2345; exp_pc[0] = 12'h001; exp_addr[0] = 8'h02;
        exp_instr[1] = 16'h10A5; exp_pc[1] = 12'h0A5; exp_addr[1] = 8'h4A;
        exp_instr[2] = 16'h1FFF; exp_pc[2] = 12'hFFF; exp_addr[2] = 8'hFE;
        exp_instr[3] = 16'h2345; exp_pc[3] = 12'h000; exp_addr[3] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            wait_exec_a(60, got);
            n_checks++; if (!got) $display("FAIL seq_exec[%0d]: got none want pulse", k); else n_pass++;
            n_checks++; if (a_instr !== exp_instr[k]) $display("FAIL seq_instr[%0d]: got %h want %h", k, a_instr, exp_instr[k]); else n_pass++;
            n_checks++; if (a_pc !== exp_pc[k])       $display("FAIL seq_pc[%0d]: got %h want %h", k, a_pc, exp_pc[k]);          else n_pass++;
            n_checks++; if (a_addr !== exp_addr[k])   $display("FAIL seq_addr[%0d]: got %h want %h", k, a_addr, exp_addr[k]);    else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (a_exec !== 1'b0) $display("FAIL seq_exec_width[%0d]: got %0b want 0", k, a_exec); else n_pass++;
        end
    endtask

    task automatic test_restart_collision();
        bit got;
        int xr;
        int ex;
        xr = 0; ex = 0;
        a_auto    = 1'b0;
        a_ack_man = 1'b0;
        a_hr      = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        a_hr = 1'b0;
        mem_a[8'h01] = 8'h99;
        wait_req_a(1'b1, 20, got);
        n_checks++; if (!got || a_addr !== 8'h00) $display("FAIL coll_first_req: got req=%0b addr=%h want req=1 addr=00", got, a_addr); else n_pass++;
        a_ack_man = 1'b1;
        wait_req_a(1'b0, 10, got);
        n_checks++; if (!got) $display("FAIL coll_first_ack: got req still high want low"); else n_pass++;
        a_ack_man = 1'b0;
        wait_req_a(1'b1, 20, got);
        n_checks++; if (!got || a_addr !== 8'h01) $display("FAIL coll_second_req: got req=%0b addr=%h want req=1 addr=01", got, a_addr); else n_pass++;
        a_hr = 1'b1;
        @(posedge clk); #1;
        a_ack_man = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (a_xrst) xr++;
            if (a_exec) ex++;
        end
        n_checks++; if (xr != 1)          $display("FAIL coll_xrst: got %0d want 1", xr);       else n_pass++;
        n_checks++; if (ex != 0)          $display("FAIL coll_exec: got %0d want 0", ex);       else n_pass++;
        n_checks++; if (a_pc !== 12'h000) $display("FAIL coll_pc: got %h want 000", a_pc);      else n_pass++;
        n_checks++; if (a_busy !== 1'b0)  $display("FAIL coll_hold_busy: got %0b want 0", a_busy); else n_pass++;
        n_checks++; if (a_req !== 1'b0)   $display("FAIL coll_hold_req: got %0b want 0", a_req); else n_pass++;
        n_checks++; if (a_instr[15:8] !== 8'h23) $display("FAIL coll_hi_byte: got %h want 23", a_instr[15:8]); else n_pass++;
        n_checks++; if (a_instr[7:0] === 8'h99)  $display("FAIL coll_lo_byte: got %h want not 99", a_instr[7:0]); else n_pass++;
        a_ack_man = 1'b0;
        a_hr      = 1'b0;
        wait_req_a(1'b1, 20, got);
        n_checks++; if (!got || a_addr !== 8'h00) $display("FAIL coll_resume: got req=%0b addr=%h want req=1 addr=00", got, a_addr); else n_pass++;
    endtask

    task automatic test_wide_instruction();
        logic [7:0] addrs [4];
        int         na;
        logic       prev;
        bit         got;
        na = 0; prev = 1'b0; got = 1'b0;
        for (int k = 0; k < 4; k++) addrs[k] = 8'hFF;
        @(negedge clk);
        b_rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (b_exec) begin
                got = 1'b1;
                break;
            end
            if (b_req && !prev && na < 4) begin
                addrs[na] = b_addr;
                na++;
            end
            prev = b_req;
        end
        n_checks++; if (!got)    $display("FAIL wide_exec: got none want pulse"); else n_pass++;
        n_checks++; if (na != 4) $display("FAIL wide_chunks: got %0d want 4", na); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (addrs[k] !== 8'(k)) $display("FAIL wide_addr[%0d]: got %h want %h", k, addrs[k], 8'(k)); else n_pass++;
        end
        n_checks++; if (b_instr !== 32'hDEADBEEF) $display("FAIL wide_instr: got %h want DEADBEEF", b_instr); else n_pass++;
        n_checks++; if (b_pc !== 12'h001)  $display("FAIL wide_pc: got %h want 001", b_pc);     else n_pass++;
        n_checks++; if (b_addr !== 8'h04)  $display("FAIL wide_next_addr: got %h want 04", b_addr); else n_pass++;
        n_checks++; if (b_err !== 1'b0 || b_xrst !== 1'b0 || b_busy !== 1'b1)
            $display("FAIL wide_status: got err=%0b xrst=%0b busy=%0b want 0 0 1", b_err, b_xrst, b_busy);
        else n_pass++;
    endtask

    task automatic test_slow_tick_and_async_reset();
        int n;
        bit got;
        n = 0;
        @(negedge clk);
        c_rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (c_req) begin
                n = i;
                break;
            end
        end
        n_checks++; if (n != 8) $display("FAIL slow_first_req: got cycle %0d want 8", n); else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (c_exec) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++; if (!got) $display("FAIL slow_exec: got none want pulse"); else n_pass++;
        n_checks++; if (c_instr !== 16'h2345) $display("FAIL slow_instr: got %h want 2345", c_instr); else n_pass++;
        n_checks++; if (c_pc !== 12'h001 || c_addr !== 8'h02) $display("FAIL slow_pc_addr: got pc=%h addr=%h want 001 02", c_pc, c_addr); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (c_exec !== 1'b0) $display("FAIL slow_exec_width: got %0b want 0", c_exec); else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (c_req) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (!c_req) begin
                    got = 1'b1;
                    break;
                end
            end
        end
        n_checks++; if (!got) $display("FAIL slow_reach_rel: got no req release want release"); else n_pass++;
        #2;
        c_rst = 1'b0;
        #1;
        n_checks++; if (c_req !== 1'b0 || c_pc !== 12'h000 || c_addr !== 8'h00)
            $display("FAIL async_rst_fetch: got req=%0b pc=%h addr=%h want 0 000 00", c_req, c_pc, c_addr);
        else n_pass++;
        n_checks++; if (c_instr !== 16'h0000 || c_exec !== 1'b0 || c_xrst !== 1'b0 || c_err !== 1'b0 || c_busy !== 1'b1)
            $display("FAIL async_rst_status: got instr=%h exec=%0b xrst=%0b err=%0b busy=%0b want 0000 0 0 0 1",
                     c_instr, c_exec, c_xrst, c_err, c_busy);
        else n_pass++;
        @(negedge clk);
        c_rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (c_req) begin
                n = i;
                break;
            end
        end
        n_checks++; if (n != 8) $display("FAIL slow_req_after_rst: got cycle %0d want 8", n); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        init_mems();
        test_reset();
        test_timeout();
        test_restart_from_halt();
        test_sequential_and_jump();
        test_restart_collision();
        test_wide_instruction();
        test_slow_tick_and_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
